serialtopar: RTL and testbench
==============================

Name: serialtopar

Overview:
- Receive-side counterpart of the parallel-to-serial stage, sitting directly downstream of it.
- Consumes the 1-bit serial stream clocked on clk_8f and reassembles it into 8-bit words, MSB first.
- Locks onto the link after a run of consecutive comma/idle symbols (0xBC), then delivers data words with a valid strobe.
- Comma words received while locked are idle, not data.

Parameters:
WIDTH, 8, word width in bits; the bit counter is sized as clog2(WIDTH).
COMMA, 8'hBC, idle/sync symbol the upstream serializer emits when its valid_in is low.
BC_THRESHOLD, 4, number of consecutive COMMA words required to enter ACTIVE.

Ports:
clk_8f  input  1  serial bit clock (8x word rate); all logic on rising edge.
reset  input  1  synchronous, active-high reset.
data_in  input  1  serial bit stream from the parallel-to-serial stage, MSB first.
data_out  output  WIDTH  last received data word (registered).
valid_out  output  1  one-word-period strobe: data_out holds a non-comma word received while ACTIVE.
active  output  1  link locked: BC_THRESHOLD consecutive commas seen.

Behaviour:
- Reset (reset=1 at an edge):
  - Outputs: data_out=0, valid_out=0, active=0.
  - Internal: shift register=0, bit counter=0, comma counter=0, state=SEARCH.
  - Reset asserted mid-word or mid-ACTIVE discards the partial word and returns to SEARCH at that edge.
- Bit capture:
  - Every edge with reset=0: shift <= {shift[WIDTH-2:0], data_in}; bit counter increments mod WIDTH.
  - The first bit after reset release is the MSB of word 0.
- Word boundary: the edge at which the bit counter wraps from WIDTH-1 to 0. At that edge, word = {shift[WIDTH-2:0], data_in} is evaluated. Outputs update at that same edge and hold for the next WIDTH cycles.
- States:
  - SEARCH:
    - word==COMMA: comma counter +1.
    - Otherwise: comma counter cleared.
    - Comma counter reaching BC_THRESHOLD moves to ACTIVE and sets active=1 at that boundary edge.
    - valid_out=0 throughout; data_out unchanged.
  - ACTIVE:
    - word!=COMMA: data_out<=word, valid_out<=1.
    - word==COMMA: valid_out<=0, data_out holds its previous value.
    - active stays 1 until reset; data words do not drop lock.
- Boundary conditions:
  - Comma counter saturates at BC_THRESHOLD.
  - A non-comma word in SEARCH at count BC_THRESHOLD-1 clears the count and does not lock.
- Timing:
  - Latency: the LSB of a word is sampled at edge N; data_out/valid_out are valid from edge N through edge N+8.
  - Back-to-back data words keep valid_out high continuously.
  - valid_out is never asserted outside ACTIVE.

Optional Feature:
- Macro: COMMA_ALIGN_EN.
- Defined:
  - In SEARCH, the full shift value is compared against COMMA on every edge, not only at boundaries.
  - On a match, the bit counter is forced so that this edge is a word boundary. Alignment uses a sliding window: the stream may start at any bit offset relative to reset release.
  - Commas are counted only at aligned boundaries after the realignment.
  - ACTIVE is unaffected; no realignment occurs once locked.
- Undefined: alignment is fixed by reset release; the upstream stage must be reset on the same edge.

Test Plan:
- Reset, then 4x 0xBC followed by 0x5A, 0x3C → active=1 at the 4th BC boundary; valid_out=1 with data_out=0x5A for 8 cycles, then 0x3C; valid_out stays high across both.
- Locked, send 0x12, 0xBC, 0x34 → data_out=0x12 valid_out=1; then valid_out=0 with data_out=0x12 held; then 0x34 valid_out=1.
- SEARCH: 3x 0xBC, 0x00, 3x 0xBC → active stays 0; a 4th BC then gives active=1.
- Assert reset mid-word in ACTIVE (after 3 bits of 0xFF) → next edge all outputs 0, active=0; 4 BCs needed to relock.
- Loopback through the parallel-to-serial stage (its valid_in low 4 words, then data 0xA1, 0xB2, 0xC3) → data_out sequence A1, B2, C3 with valid_out matching the upstream valid_in delayed by one word plus serialization latency.
- COMMA_ALIGN_EN: 3 garbage bits (101) then 5x 0xBC, then 0x77 → realigns on the first BC, active=1 after 4 aligned BCs, data_out=0x77 valid_out=1.

Source files
------------

// File: rtl/serialtopar.sv
// serialtopar: serial-to-parallel receiver with comma-based link lock.
// Shifts a 1-bit MSB-first stream into WIDTH-bit words and counts
// consecutive COMMA words while searching. Once BC_THRESHOLD commas have
// been seen it locks (active=1) and delivers non-comma words with valid_out.
// Optional macro COMMA_ALIGN_EN: while searching, a sliding-window comma
// match anywhere in the stream realigns the word boundary to that bit.
module serialtopar #(
    parameter int               WIDTH        = 8,
    parameter logic [WIDTH-1:0] COMMA        = WIDTH'(8'hBC),
    parameter int               BC_THRESHOLD = 4
) (
    input  logic             clk_8f,
    input  logic             reset,
    input  logic             data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             valid_out,
    output logic             active
);

    localparam int               CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);
    localparam int               CC_W  = $clog2(BC_THRESHOLD + 1);
    localparam logic [CC_W-1:0]  THR   = CC_W'(BC_THRESHOLD);

    typedef enum logic {SEARCH, ACTIVE} state_t;

    // Comma run length never exceeds the lock threshold.
    function automatic logic [CC_W-1:0] sat_inc(input logic [CC_W-1:0] c);
        return (c >= THR) ? THR : c + CC_W'(1);
    endfunction

    state_t           state, state_nx;
    logic [WIDTH-2:0] shift_p0;
    logic [CNT_W-1:0] bit_cnt, bit_nx;
    logic [CC_W-1:0]  comma_cnt, comma_nx, comma_inc;
    logic [WIDTH-1:0] word_p0, data_nx;
    logic             valid_nx, active_nx, boundary, realign;

    // Next-state and output decode: word assembly, comma counting, lock, delivery.
    always_comb begin
        word_p0   = {shift_p0, data_in};
        boundary  = (bit_cnt == LAST);
        state_nx  = state;
        bit_nx    = boundary ? '0 : bit_cnt + CNT_W'(1);
        comma_nx  = comma_cnt;
        comma_inc = sat_inc(comma_cnt);
        data_nx   = data_out;
        valid_nx  = valid_out;
        active_nx = active;
`ifdef COMMA_ALIGN_EN
        // An off-boundary comma match restarts the run on a new alignment.
        realign   = (state == SEARCH) && (word_p0 == COMMA) && !boundary;
`else
        realign   = 1'b0;
`endif
        case (state)
            SEARCH: begin
                valid_nx = 1'b0;
                if (realign) begin
                    bit_nx    = '0;
                    comma_inc = CC_W'(1);
                end
                if (boundary || realign) begin
                    if (word_p0 == COMMA) begin
                        comma_nx = comma_inc;
                        if (comma_inc == THR) begin
                            state_nx  = ACTIVE;
                            active_nx = 1'b1;
                        end
                    end else begin
                        comma_nx = '0;
                    end
                end
            end
            ACTIVE: begin
                if (boundary) begin
                    if (word_p0 != COMMA) begin
                        data_nx  = word_p0;
                        valid_nx = 1'b1;
                    end else begin
                        valid_nx = 1'b0;
                    end
                end
            end
            default: state_nx = SEARCH;
        endcase
    end

    // State, shift register and registered outputs; reset discards any partial word.
    always_ff @(posedge clk_8f) begin
        if (reset) begin
            state     <= SEARCH;
            shift_p0  <= '0;
            bit_cnt   <= '0;
            comma_cnt <= '0;
            data_out  <= '0;
            valid_out <= 1'b0;
            active    <= 1'b0;
        end else begin
            state     <= state_nx;
            shift_p0  <= word_p0[WIDTH-2:0];
            bit_cnt   <= bit_nx;
            comma_cnt <= comma_nx;
            data_out  <= data_nx;
            valid_out <= valid_nx;
            active    <= active_nx;
        end
    end

endmodule

// File: tb/tb_serialtopar.sv
// tb_serialtopar: vector table, hand-written corner sequences and a
// randomized word stream checked against a word-level behavioural model.
module tb_serialtopar;

    localparam logic [7:0] BC  = 8'hBC;
    localparam int         THR = 4;

    logic       clk_8f = 1'b0;
    logic       reset  = 1'b1;
    logic       data_in = 1'b0;
    logic [7:0] data_out;
    logic       valid_out;
    logic       active;

    int total = 0;
    int bad   = 0;

    // Expectations currently held by the outputs (checked mid-word).
    logic       p_act = 1'b0;
    logic       p_val = 1'b0;
    logic [7:0] p_dat = 8'h00;

    // Word-level reference model state.
    int         m_run = 0;
    logic       m_act = 1'b0;
    logic       m_val = 1'b0;
    logic [7:0] m_dat = 8'h00;

    typedef struct {
        logic [7:0] word;
        logic       e_act;
        logic       e_val;
        logic [7:0] e_dat;
    } vec_t;

    vec_t vecs[9];

    serialtopar dut (
        .clk_8f    (clk_8f),
        .reset     (reset),
        .data_in   (data_in),
        .data_out  (data_out),
        .valid_out (valid_out),
        .active    (active)
    );

    always #5 clk_8f = ~clk_8f;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string name, input logic ea, input logic ev, input logic [7:0] ed);
        check({name, ".active"}, {7'd0, active}, {7'd0, ea});
        check({name, ".valid"}, {7'd0, valid_out}, {7'd0, ev});
        check({name, ".data"}, data_out, ed);
    endtask

    task automatic send_bit(input logic b);
        data_in = b;
        @(posedge clk_8f);
        #1;
    endtask

    task automatic send_word(input logic [7:0] w);
        for (int i = 7; i >= 0; i--) send_bit(w[i]);
    endtask

    // Send a word, confirm previous outputs hold mid-word, then check new outputs.
    task automatic apply_word(input string name, input logic [7:0] w,
                              input logic ea, input logic ev, input logic [7:0] ed);
        for (int i = 7; i >= 4; i--) send_bit(w[i]);
        check_outs({name, ".hold"}, p_act, p_val, p_dat);
        for (int i = 3; i >= 0; i--) send_bit(w[i]);
        check_outs(name, ea, ev, ed);
        p_act = ea;
        p_val = ev;
        p_dat = ed;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk_8f);
        #1;
        reset = 1'b0;
        p_act = 1'b0; p_val = 1'b0; p_dat = 8'h00;
        m_run = 0; m_act = 1'b0; m_val = 1'b0; m_dat = 8'h00;
    endtask

    // Behavioural model: consecutive-comma run decides lock; locked non-commas are data.
    task automatic model_word(input logic [7:0] w);
        if (!m_act) begin
            m_run = (w == BC) ? ((m_run + 1 > THR) ? THR : m_run + 1) : 0;
            m_act = (m_run == THR);
            m_val = 1'b0;
        end else if (w != BC) begin
            m_dat = w;
            m_val = 1'b1;
        end else begin
            m_val = 1'b0;
        end
    endtask

    initial begin
        logic [7:0] w;
        vecs[0] = '{BC,    1'b0, 1'b0, 8'h00};
        vecs[1] = '{BC,    1'b0, 1'b0, 8'h00};
        vecs[2] = '{BC,    1'b0, 1'b0, 8'h00};
        vecs[3] = '{BC,    1'b1, 1'b0, 8'h00};
        vecs[4] = '{8'h5A, 1'b1, 1'b1, 8'h5A};
        vecs[5] = '{8'h3C, 1'b1, 1'b1, 8'h3C};
        vecs[6] = '{8'h12, 1'b1, 1'b1, 8'h12};
        vecs[7] = '{BC,    1'b1, 1'b0, 8'h12};
        vecs[8] = '{8'h34, 1'b1, 1'b1, 8'h34};

        // Reset state
        do_reset();
        check_outs("reset", 1'b0, 1'b0, 8'h00);

        // Lock, back-to-back data, idle comma while locked
        for (int i = 0; i < 9; i++)
            apply_word($sformatf("vec%0d", i), vecs[i].word, vecs[i].e_act, vecs[i].e_val, vecs[i].e_dat);

        // Broken comma run in SEARCH does not lock
        do_reset();
        for (int i = 0; i < 3; i++) apply_word("srch_a", BC, 1'b0, 1'b0, 8'h00);
        apply_word("srch_break", 8'h00, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 3; i++) apply_word("srch_b", BC, 1'b0, 1'b0, 8'h00);
        apply_word("srch_lock", BC, 1'b1, 1'b0, 8'h00);
        apply_word("srch_data", 8'h00, 1'b1, 1'b1, 8'h00);

        // Reset mid-word while ACTIVE, then relock
        apply_word("pre_rst", 8'hE7, 1'b1, 1'b1, 8'hE7);
        for (int i = 0; i < 3; i++) send_bit(1'b1);
        do_reset();
        check_outs("mid_rst", 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 3; i++) apply_word("relock_a", BC, 1'b0, 1'b0, 8'h00);
        apply_word("relock", BC, 1'b1, 1'b0, 8'h00);

        // Loopback through an ideal serializer: commas while its valid_in is low
        do_reset();
        begin
            logic       lv[7] = '{0, 0, 0, 0, 1, 1, 1};
            logic [7:0] ld[7] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'hA1, 8'hB2, 8'hC3};
            for (int i = 0; i < 7; i++) begin
                send_word(lv[i] ? ld[i] : BC);
                model_word(lv[i] ? ld[i] : BC);
                check_outs($sformatf("loop%0d", i), m_act, m_val, m_dat);
            end
        end

`ifndef COMMA_ALIGN_EN
        // Random stream from reset, comma-biased so lock is reached
        do_reset();
        for (int i = 0; i < 60; i++) begin
            w = ($urandom_range(0, 9) < 5) ? BC : 8'($urandom);
            send_word(w);
            model_word(w);
            check_outs($sformatf("rand%0d", i), m_act, m_val, m_dat);
        end
`else
        // Stream offset by 3 garbage bits: realign on the first comma
        do_reset();
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        for (int i = 0; i < 3; i++) begin
            send_word(BC);
            check_outs("align_srch", 1'b0, 1'b0, 8'h00);
        end
        send_word(BC);
        check_outs("align_lock", 1'b1, 1'b0, 8'h00);
        send_word(BC);
        check_outs("align_idle", 1'b1, 1'b0, 8'h00);
        send_word(8'h77);
        check_outs("align_data", 1'b1, 1'b1, 8'h77);
        // Random locked traffic
        for (int i = 0; i < 40; i++) begin
            w = ($urandom_range(0, 3) == 0) ? BC : 8'($urandom);
            send_word(w);
            check_outs($sformatf("arand%0d", i), 1'b1, (w != BC), (w != BC) ? w : p_dat);
            if (w != BC) p_dat = w;
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
